// File: rtl/block_sync_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// system_parameters
// Shared constants and types for the block-synchronisation path.
//   BLOCK_SIZE   : block period in words (comma word is index 0)
//   LOCK_COUNT   : consecutive well-spaced commas needed to lock
//   UNLOCK_COUNT : consecutive missing commas needed to lose lock
//   COMMA_BYTE   : comma symbol searched for in every byte lane
//   sync_state_t : synchroniser FSM states
//   sat_inc16    : 16-bit increment that sticks at all-ones
// ---------------------------------------------------------------------------
package system_parameters;

    localparam int         BLOCK_SIZE   = 1024;
    localparam int         LOCK_COUNT   = 3;
    localparam int         UNLOCK_COUNT = 2;
    localparam logic [7:0] COMMA_BYTE   = 8'hFC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/block_sync_ctrl_comma_detect.sv
// ---------------------------------------------------------------------------
// comma_detect
// Purely combinational comma finder: flags a word when any of its four
// bytes equals COMMA_BYTE. Kept separate so other stream consumers can
// reuse it.
// Ports:
//   data     in  32  word to inspect
//   commaHit out 1   at least one byte lane holds the comma symbol
// ---------------------------------------------------------------------------
module comma_detect #(
    parameter logic [7:0] COMMA_BYTE = system_parameters::COMMA_BYTE
) (
    input  logic [31:0] data,
    output logic        commaHit
);

    logic [3:0] byte_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_hit[gi] = (data[8*gi +: 8] == COMMA_BYTE);
        end
    endgenerate

    assign commaHit = |byte_hit;

endmodule

// File: rtl/block_sync_ctrl.sv
// ---------------------------------------------------------------------------
// block_sync_ctrl
// Block-synchronisation controller. Hunts for comma words, verifies that
// they repeat every BLOCK_SIZE words, locks after LOCK_COUNT good commas and
// then flywheels through up to UNLOCK_COUNT-1 consecutive missing commas.
// All outputs are registered: the values at cycle t+1 describe inData at t.
//
// Optional feature macro: BLOCK_SYNC_STATS_EN
//   defined   -> syncLossCnt / spuriousCnt saturating statistics present
//   undefined -> both statistics ports read 16'h0000, FSM unchanged
//
// Ports:
//   clk          in   1      system clock
//   rst          in   1      asynchronous active-high reset
//   inData       in   32     received word stream, one word per cycle
//   outData      out  32     inData delayed one register
//   blockStart   out  1      outData is the index-0 word while locked
//   sampleIdx    out  log2B  position of outData within its block
//   dataValid    out  1      locked and sampleIdx != 0
//   locked       out  1      FSM is in LOCKED
//   syncLossCnt  out  16     saturating count of LOCKED->HUNT transitions
//   spuriousCnt  out  16     saturating count of off-position commas in LOCKED
// ---------------------------------------------------------------------------
module block_sync_ctrl
    import system_parameters::*;
#(
    parameter int         BLOCK_SIZE   = system_parameters::BLOCK_SIZE,
    parameter int         LOCK_COUNT   = system_parameters::LOCK_COUNT,
    parameter int         UNLOCK_COUNT = system_parameters::UNLOCK_COUNT,
    parameter logic [7:0] COMMA_BYTE   = system_parameters::COMMA_BYTE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   inData,
    output logic [31:0]                   outData,
    output logic                          blockStart,
    output logic [$clog2(BLOCK_SIZE)-1:0] sampleIdx,
    output logic                          dataValid,
    output logic                          locked,
    output logic [15:0]                   syncLossCnt,
    output logic [15:0]                   spuriousCnt
);

    localparam int IDX_W  = $clog2(BLOCK_SIZE);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_COUNT - 1);

    sync_state_t       state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [GOOD_W-1:0] good_cnt_reg;
    logic [MISS_W-1:0] miss_cnt_reg;

    logic              comma_hit;
    logic              expected;
    logic [IDX_W-1:0]  word_idx;
    logic              sync_loss_evt;

    comma_detect #(
        .COMMA_BYTE (COMMA_BYTE)
    ) u_comma_detect (
        .data     (inData),
        .commaHit (comma_hit)
    );

    // idx_reg holds the position of the previous word, so the word now on
    // inData sits at idx_reg+1 (mod BLOCK_SIZE). A comma is due when that
    // position wraps to 0.
    assign expected = (idx_reg == IDX_LAST);
    assign word_idx = expected ? '0 : idx_reg + 1'b1;

    // The miss that reaches UNLOCK_COUNT drops lock.
    assign sync_loss_evt = (state_reg == LOCKED) && expected && !comma_hit &&
                           (miss_cnt_reg == MISS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= HUNT;
            idx_reg      <= '0;
            good_cnt_reg <= '0;
            miss_cnt_reg <= '0;
            outData      <= '0;
            sampleIdx    <= '0;
            blockStart   <= 1'b0;
            dataValid    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            outData    <= inData;
            blockStart <= 1'b0;
            dataValid  <= 1'b0;
            locked     <= 1'b0;

            case (state_reg)
                HUNT: begin
                    sampleIdx <= '0;
                    if (comma_hit) begin
                        state_reg    <= VERIFY;
                        idx_reg      <= '0;
                        good_cnt_reg <= GOOD_ONE;
                    end
                end

                VERIFY: begin
                    if (expected) begin
                        idx_reg   <= '0;
                        sampleIdx <= '0;
                        if (!comma_hit) begin
                            state_reg <= HUNT;
                        end else if (good_cnt_reg == GOOD_LAST) begin
                            // Lock is announced together with the block start
                            // of the comma that completed the run.
                            state_reg    <= LOCKED;
                            miss_cnt_reg <= '0;
                            locked       <= 1'b1;
                            blockStart   <= 1'b1;
                        end else begin
                            good_cnt_reg <= good_cnt_reg + 1'b1;
                        end
                    end else if (comma_hit) begin
                        // Early comma: treat it as a new candidate phase.
                        idx_reg      <= '0;
                        sampleIdx    <= '0;
                        good_cnt_reg <= GOOD_ONE;
                    end else begin
                        idx_reg   <= word_idx;
                        sampleIdx <= word_idx;
                    end
                end

                LOCKED: begin
                    // Flywheel: the phase advances regardless of the data.
                    idx_reg   <= word_idx;
                    sampleIdx <= word_idx;
                    if (!expected) begin
                        locked    <= 1'b1;
                        dataValid <= 1'b1;
                    end else if (comma_hit) begin
                        miss_cnt_reg <= '0;
                        locked       <= 1'b1;
                        blockStart   <= 1'b1;
                    end else if (sync_loss_evt) begin
                        state_reg    <= HUNT;
                        miss_cnt_reg <= '0;
                    end else begin
                        // Tolerated miss: still mark the block boundary.
                        miss_cnt_reg <= miss_cnt_reg + 1'b1;
                        locked       <= 1'b1;
                        blockStart   <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= HUNT;
                    sampleIdx <= '0;
                end
            endcase
        end
    end

`ifdef BLOCK_SYNC_STATS_EN
    logic        spurious_evt;
    logic [15:0] sync_loss_cnt_reg;
    logic [15:0] spurious_cnt_reg;

    assign spurious_evt = (state_reg == LOCKED) && !expected && comma_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_loss_cnt_reg <= '0;
            spurious_cnt_reg  <= '0;
        end else begin
            if (sync_loss_evt) begin
                sync_loss_cnt_reg <= sat_inc16(sync_loss_cnt_reg);
            end
            if (spurious_evt) begin
                spurious_cnt_reg <= sat_inc16(spurious_cnt_reg);
            end
        end
    end

    assign syncLossCnt = sync_loss_cnt_reg;
    assign spuriousCnt = spurious_cnt_reg;
`else
    assign syncLossCnt = 16'h0000;
    assign spuriousCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_block_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_block_sync_ctrl
// Scoreboard bench for block_sync_ctrl. Every driven word is passed through
// a reference model that tracks the block phase as an absolute cycle anchor;
// the predicted output is queued and a monitor compares it one cycle later.
// Directed checks at the interesting cycles use constants taken from the
// block's intended behaviour.
// ---------------------------------------------------------------------------
module tb_block_sync_ctrl;

    localparam int B      = 1024;
    localparam int LOCK   = 3;
    localparam int UNLOCK = 2;
`ifdef BLOCK_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] inData;
    logic [31:0] outData;
    logic        blockStart;
    logic [9:0]  sampleIdx;
    logic        dataValid;
    logic        locked;
    logic [15:0] syncLossCnt;
    logic [15:0] spuriousCnt;

    block_sync_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .inData      (inData),
        .outData     (outData),
        .blockStart  (blockStart),
        .sampleIdx   (sampleIdx),
        .dataValid   (dataValid),
        .locked      (locked),
        .syncLossCnt (syncLossCnt),
        .spuriousCnt (spuriousCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          idx;
        bit          bs;
        bit          dv;
        bit          lk;
        int          sl;
        int          sp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: mode 0=hunting, 1=verifying, 2=locked.
    int m_t, m_mode, m_anchor, m_good, m_miss, m_sl, m_sp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, required %0h (time %0t)", name, act, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_t = 0; m_mode = 0; m_anchor = 0; m_good = 0; m_miss = 0; m_sl = 0; m_sp = 0;
    endfunction

    function automatic void model_step(input logic [31:0] w);
        bit   hit = 1'b0;
        int   p;
        exp_t e;
        for (int b = 0; b < 4; b++) if (w[8*b +: 8] == 8'hFC) hit = 1'b1;
        p = (m_t - m_anchor) % B;
        case (m_mode)
            0: if (hit) begin m_mode = 1; m_anchor = m_t; m_good = 1; end
            1: begin
                if (p == 0) begin
                    if (hit) begin
                        m_good++;
                        if (m_good == LOCK) begin m_mode = 2; m_miss = 0; end
                    end else m_mode = 0;
                end else if (hit) begin
                    m_anchor = m_t; m_good = 1;
                end
            end
            default: begin
                if (p == 0) begin
                    if (hit) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss == UNLOCK) begin
                            m_mode = 0; m_miss = 0;
                            if (m_sl < 65535) m_sl++;
                        end
                    end
                end else if (hit && m_sp < 65535) m_sp++;
            end
        endcase
        p      = (m_t - m_anchor) % B;
        e.data = w;
        e.idx  = (m_mode == 0) ? 0 : p;
        e.lk   = (m_mode == 2);
        e.bs   = e.lk && (p == 0);
        e.dv   = e.lk && (p != 0);
        e.sl   = STATS ? m_sl : 0;
        e.sp   = STATS ? m_sp : 0;
        exp_q.push_back(e);
        m_t++;
    endfunction

    // Monitor: one output per driven word, compared just after the edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outData",     outData,            e.data);
            check("sampleIdx",   32'(sampleIdx),     e.idx);
            check("blockStart",  32'(blockStart),    32'(e.bs));
            check("dataValid",   32'(dataValid),     32'(e.dv));
            check("locked",      32'(locked),        32'(e.lk));
            check("syncLossCnt", 32'(syncLossCnt),   e.sl);
            check("spuriousCnt", 32'(spuriousCnt),   e.sp);
        end
    end

    function automatic logic [31:0] noise_word();
        logic [31:0] w;
        w = $urandom;
        for (int b = 0; b < 4; b++) if (w[8*b +: 8] == 8'hFC) w[8*b +: 8] = 8'h5A;
        return w;
    endfunction

    function automatic logic [31:0] comma_word(input int lane);
        logic [31:0] w;
        w = noise_word();
        w[8*lane +: 8] = 8'hFC;
        return w;
    endfunction

    task automatic drive(input logic [31:0] w);
        @(negedge clk);
        inData = w;
        model_step(w);
    endtask

    task automatic noise(input int n);
        for (int i = 0; i < n; i++) drive(noise_word());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outData"},    outData,            32'h0);
        check({tag, "_sampleIdx"},  32'(sampleIdx),     32'h0);
        check({tag, "_blockStart"}, 32'(blockStart),    32'h0);
        check({tag, "_dataValid"},  32'(dataValid),     32'h0);
        check({tag, "_locked"},     32'(locked),        32'h0);
        check({tag, "_syncLoss"},   32'(syncLossCnt),   32'h0);
        check({tag, "_spurious"},   32'(spuriousCnt),   32'h0);
    endtask

    initial begin : stim
        int dv_cnt;
        int n;
        rst    = 1'b1;
        inData = 32'h0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #3;
        rst = 1'b0;
        $display("txn reset: released at %0t", $time);

        // Lock on 1024-periodic commas in byte 0
        noise($urandom_range(0, 40));
        for (int k = 1; k <= 3; k++) begin
            drive(comma_word(0));
            settle();
            check($sformatf("lock_c%0d_locked", k), 32'(locked), (k == 3) ? 32'h1 : 32'h0);
            check($sformatf("lock_c%0d_start", k), 32'(blockStart), (k == 3) ? 32'h1 : 32'h0);
            check($sformatf("lock_c%0d_idx", k), 32'(sampleIdx), 32'h0);
            if (k < 3) noise(B - 1);
        end
        dv_cnt = 0;
        for (int i = 0; i < B - 1; i++) begin
            drive(noise_word());
            settle();
            if (dataValid === 1'b1) dv_cnt++;
        end
        check("lock_dataValid_run", dv_cnt, B - 1);
        $display("txn lock: dataValid cycles %0d", dv_cnt);

        // Flywheel through one miss, then lose lock on two
        drive(noise_word());
        settle();
        check("fly1_start", 32'(blockStart), 32'h1);
        check("fly1_locked", 32'(locked), 32'h1);
        check("fly1_idx", 32'(sampleIdx), 32'h0);
        noise(B - 1);
        drive(comma_word($urandom_range(0, 3)));
        settle();
        check("fly_recover_locked", 32'(locked), 32'h1);
        noise(B - 1);
        drive(noise_word());
        settle();
        check("miss1_locked", 32'(locked), 32'h1);
        check("miss1_start", 32'(blockStart), 32'h1);
        noise(B - 1);
        drive(noise_word());
        settle();
        check("miss2_locked", 32'(locked), 32'h0);
        check("miss2_start", 32'(blockStart), 32'h0);
        check("miss2_dataValid", 32'(dataValid), 32'h0);
        check("miss2_syncLoss", 32'(syncLossCnt), STATS ? 32'h1 : 32'h0);
        $display("txn flywheel: lock dropped at %0t", $time);

        // Restart inside VERIFY at idx 500
        drive(comma_word(0));
        noise(B - 1);
        drive(comma_word(1));
        noise(499);
        drive(comma_word(2));
        settle();
        check("restart_idx", 32'(sampleIdx), 32'h0);
        check("restart_locked", 32'(locked), 32'h0);
        noise(B - 1);
        drive(comma_word(0));
        settle();
        check("restart_p1_locked", 32'(locked), 32'h0);
        check("restart_p1_start", 32'(blockStart), 32'h0);
        noise(B - 1);
        drive(comma_word(0));
        settle();
        check("restart_p2_locked", 32'(locked), 32'h1);
        check("restart_p2_start", 32'(blockStart), 32'h1);
        $display("txn verify_restart: relocked at %0t", $time);

        // Spurious comma in byte 3 at idx 300 while locked
        noise(299);
        drive(32'hFC00_0000);
        settle();
        check("spur_locked", 32'(locked), 32'h1);
        check("spur_idx", 32'(sampleIdx), 32'd300);
        check("spur_dataValid", 32'(dataValid), 32'h1);
        check("spur_count", 32'(spuriousCnt), STATS ? 32'h1 : 32'h0);
        noise(B - 301);
        drive(comma_word(0));
        settle();
        check("spur_phase_start", 32'(blockStart), 32'h1);
        $display("txn spurious: phase held at %0t", $time);

        // Randomised blocks: commas sometimes missing, occasional strays
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < B; i++) begin
                if (i == 0) begin
                    if ($urandom_range(0, 99) < 80) drive(comma_word($urandom_range(0, 3)));
                    else drive(noise_word());
                end else if ($urandom_range(0, 999) == 0) begin
                    drive(comma_word($urandom_range(0, 3)));
                end else begin
                    drive(noise_word());
                end
            end
            $display("txn random_block %0d: model mode %0d", blk, m_mode);
        end

        // Asynchronous reset mid-block while locked
        n = 0;
        while (m_mode != 2 && n < 6) begin
            drive(comma_word(0));
            noise(B - 1);
            n++;
        end
        noise($urandom_range(100, 800));
        settle();
        check("prereset_locked", 32'(locked), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(posedge clk);
        #2;
        check_all_zero("held_rst");
        inData = 32'h0;
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(comma_word(0));
            settle();
            check($sformatf("relock_c%0d_locked", k), 32'(locked), (k == 3) ? 32'h1 : 32'h0);
            if (k < 3) noise(B - 1);
        end
        noise(4);
        settle();
        $display("txn async_reset: relocked at %0t", $time);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_sync_ctrl.md
# block_sync_ctrl

Block-synchronisation controller in front of the sample rescaler. It watches the received 32-bit word stream for comma bytes, checks that they arrive with period BLOCK_SIZE, and declares lock after LOCK_COUNT consecutive good commas. While locked it flywheels through missing commas and emits a per-block start strobe, a sample index and a data-valid qualifier. Downstream scaling-factor collection and EVM accumulation use these outputs to sequence themselves instead of free-running on raw comma hits.

## Interface
- BLOCK_SIZE, 1024: block period in words, comma word included (index 0).
- LOCK_COUNT, 3: consecutive correctly spaced commas required to enter LOCKED (≥2).
- UNLOCK_COUNT, 2: consecutive missing expected commas required to drop lock (≥1).
- COMMA_BYTE, 8'hFC: comma symbol, matched in any of the four bytes.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- inData  in  32  received word stream, one word per cycle.
- outData  out  32  inData delayed by one register.
- blockStart  out  1  pulses when outData is the index-0 word of a block while locked.
- sampleIdx  out  $clog2(BLOCK_SIZE)  position of outData within the block.
- dataValid  out  1  locked and sampleIdx≠0.
- locked  out  1  FSM is in LOCKED.
- syncLossCnt  out  16  saturating count of LOCKED→HUNT transitions.
- spuriousCnt  out  16  saturating count of commas at unexpected positions while LOCKED.

## Operation
- commaHit = any byte of inData == COMMA_BYTE (combinational). idx counter runs 0..BLOCK_SIZE-1 and wraps. expected = (next idx == 0).
- HUNT: idx ignored. On commaHit: idx←0, goodCnt←1, go to VERIFY.
- VERIFY: idx increments each cycle.
  - expected & commaHit: goodCnt+1. If this reaches LOCK_COUNT, go to LOCKED.
  - expected & !commaHit: go to HUNT.
  - !expected & commaHit: stay in VERIFY, restart with idx←0, goodCnt←1.
- LOCKED: idx increments and wraps regardless of data (flywheel).
  - expected & commaHit: missCnt←0.
  - expected & !commaHit: missCnt+1. If this reaches UNLOCK_COUNT, go to HUNT, syncLossCnt+1, missCnt←0.
  - !expected & commaHit: ignored for timing; spuriousCnt+1.
- Counters saturate at 16'hFFFF and never wrap.
- Reset, including mid-block, asserts asynchronously. It forces HUNT and clears idx, goodCnt, missCnt, both statistics counters and all outputs.

## Timing
- All outputs are registered, with one cycle of latency. Outputs at cycle t+1 describe inData at cycle t.
- locked rises in the same cycle as the blockStart for the LOCK_COUNT-th good comma.
- Flywheel misses before the threshold still produce blockStart=1 with sampleIdx=0.
- On the UNLOCK_COUNT-th miss, the output cycle shows locked=0, blockStart=0, dataValid=0.
- sampleIdx outside LOCKED/VERIFY reads 0. In VERIFY it tracks idx, but blockStart and dataValid stay 0.
- Reset values: outData 0, sampleIdx 0, blockStart/dataValid/locked 0, statistics counters 0.

## Configuration
- BLOCK_SYNC_STATS_EN defined: syncLossCnt and spuriousCnt are implemented as specified.
- BLOCK_SYNC_STATS_EN undefined: both counters are removed and their ports are tied to 16'h0000. FSM behaviour is identical.

## Structure
- system_parameters package holds:
  - BLOCK_SIZE and the COMMA_BYTE constant;
  - typedef enum logic [1:0] sync_state_t {HUNT, VERIFY, LOCKED}.
- One sub-module, comma_detect: 32-bit input, 1-bit commaHit output, purely combinational, parameterised by COMMA_BYTE. Reusable by other stream consumers.
- All remaining logic (FSM, counters, output registers) lives in block_sync_ctrl.

## Test plan
- Reset, then 1024-periodic commas (byte 0 = 8'hFC):
  - 3rd comma output cycle: locked=1, blockStart=1, sampleIdx=0.
  - dataValid is high on the next 1023 cycles.
- Once locked, drop one comma: blockStart still pulses at idx 0 and locked stays 1. Drop two consecutive commas: locked=0 on the second and syncLossCnt=1.
- In VERIFY after 2 good commas, insert a comma at idx 500:
  - VERIFY restarts there;
  - lock is declared 2 periods later, with blockStart aligned to the new phase.
- While locked, insert a comma in byte 3 (32'hFC00_0000) at idx 300: locked stays 1, phase is unchanged, spuriousCnt=1.
- Assert rst asynchronously mid-block while locked: all outputs are 0 immediately (before the next clk edge), the FSM is in HUNT, and relock needs 3 fresh commas.
- Build without BLOCK_SYNC_STATS_EN and repeat the first two scenarios: identical lock/flywheel timing, with syncLossCnt and spuriousCnt reading 0 throughout.
